// File: rtl/prbs15_checker.sv
// rtl/prbs15_checker.sv - Serial PRBS15 checker with self-synchronisation, lock tracking and saturating error/bit counters
module prbs15_checker #(
  parameter int ERR_CNT_WIDTH = 16,
  parameter int BIT_CNT_WIDTH = 32,
  parameter int LOCK_THRESH   = 32,
  parameter int LOSS_THRESH   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     data_i,
  input  logic                     valid_i,
  input  logic                     clear_i,
  output logic                     lock_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [BIT_CNT_WIDTH-1:0] bit_cnt_o,
  output logic [1:0]               state_o
);

  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_THRESH - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    SEED   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t          state;
  logic [14:0]     h;
  logic [3:0]      fill_cnt;
  logic [MW-1:0]   match_cnt;
  logic [LW-1:0]   loss_cnt;

  logic            pred;
  logic            mismatch;
  logic [14:0]     h_data;
  logic [14:0]     h_free;

  always_comb begin
    pred     = h[13] ^ h[14];
    mismatch = data_i ^ pred;
    h_data   = {h[13:0], data_i};
    h_free   = {h[13:0], pred};
  end

  assign lock_o  = (state == LOCKED);
  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= SEED;
      h         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      loss_cnt  <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;
      if (valid_i) begin
        case (state)
          VERIFY: begin
            h <= h_data;
            if (mismatch) begin
              state    <= SEED;
              fill_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              // an all-zero history satisfies the recurrence trivially, so refuse it
              if (h_data != '0) begin
                state    <= LOCKED;
                loss_cnt <= '0;
              end else begin
                state    <= SEED;
                fill_cnt <= '0;
              end
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            // free-running history: a corrupted input bit never pollutes later predictions
            h <= h_free;
            if (!(&bit_cnt_o)) bit_cnt_o <= bit_cnt_o + 1'b1;
            if (mismatch) begin
              err_o <= 1'b1;
              if (!(&err_cnt_o)) err_cnt_o <= err_cnt_o + 1'b1;
              if (loss_cnt == LOSS_LAST) begin
                state    <= SEED;
                fill_cnt <= '0;
              end else begin
                loss_cnt <= loss_cnt + 1'b1;
              end
            end else begin
              loss_cnt <= '0;
            end
          end
          default: begin
            h <= h_data;
            if (fill_cnt == 4'd14) begin
              state     <= VERIFY;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        endcase
        if (clear_i) begin
          err_cnt_o <= '0;
          bit_cnt_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs15_checker.sv
// tb/tb_prbs15_checker.sv - Directed self-checking bench for prbs15_checker
module tb_prbs15_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;

  logic        lock, err, lock4, err4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;
  logic [31:0] bit_cnt, bit_cnt4;
  logic [1:0]  state, state4;

  int checks = 0;
  int failures = 0;
  logic [14:0] gen = 15'h0001;
  int nvalid;
  int iter;
  logic seen_lock;

  always #5 clk = ~clk;

  prbs15_checker dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .lock_o(lock), .err_o(err), .err_cnt_o(err_cnt), .bit_cnt_o(bit_cnt), .state_o(state)
  );

  prbs15_checker #(.ERR_CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .lock_o(lock4), .err_o(err4), .err_cnt_o(err_cnt4), .bit_cnt_o(bit_cnt4), .state_o(state4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic next_bit();
    logic nb;
    nb  = gen[13] ^ gen[14];
    gen = {gen[13:0], nb};
    return nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic inv, input logic clr);
    data  = next_bit() ^ inv;
    valid = 1'b1;
    clear = clr;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  task automatic idle();
    data  = 1'($urandom_range(0, 1));
    valid = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    tick(); tick();
    rst = 1'b0;

    // case 1: reset state and clean lock acquisition
    chk("rst_state", state, 2'b00);
    chk("rst_lock", lock, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    chk("rst_bit_cnt", bit_cnt, 32'd0);
    send_n(14);
    chk("seed_14", state, 2'b00);
    send_n(1);
    chk("verify_15", state, 2'b01);
    send_n(31);
    chk("verify_46", state, 2'b01);
    chk("nolock_46", lock, 1'b0);
    send_n(1);
    chk("lock_47", lock, 1'b1);
    chk("state_47", state, 2'b10);
    chk("bit_cnt_47", bit_cnt, 32'd0);
    send_n(10);
    chk("bit_cnt_57", bit_cnt, 32'd10);
    chk("err_cnt_clean", err_cnt, 16'd0);

    // case 2: single inverted bit
    send(1'b1, 1'b0);
    chk("single_err_pulse", err, 1'b1);
    chk("single_err_cnt", err_cnt, 16'd1);
    chk("single_lock", lock, 1'b1);
    chk("single_bit_cnt", bit_cnt, 32'd11);
    send_n(1);
    chk("single_pulse_end", err, 1'b0);
    send_n(20);
    chk("single_after_cnt", err_cnt, 16'd1);
    chk("single_after_lock", lock, 1'b1);
    chk("single_after_bits", bit_cnt, 32'd32);

    // clear with a clean bit: clear wins over the bit increment
    send(1'b0, 1'b1);
    chk("clear_bit_cnt", bit_cnt, 32'd0);
    chk("clear_err_cnt", err_cnt, 16'd0);
    chk("clear_lock", lock, 1'b1);

    // case 3: burst of 8 errors forces resync
    for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
    chk("burst7_state", state, 2'b10);
    chk("burst7_err_cnt", err_cnt, 16'd7);
    send(1'b1, 1'b0);
    chk("burst8_state", state, 2'b00);
    chk("burst8_lock", lock, 1'b0);
    chk("burst8_err_cnt", err_cnt, 16'd8);
    chk("burst8_bit_cnt", bit_cnt, 32'd8);
    send_n(46);
    chk("relock_46", lock, 1'b0);
    send_n(1);
    chk("relock_47", lock, 1'b1);
    chk("relock_err_cnt", err_cnt, 16'd8);
    chk("relock_bit_cnt", bit_cnt, 32'd8);

    // case 5: isolated errors saturate the narrow counter
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
    end
    chk("sat_err_cnt4", err_cnt4, 4'hF);
    chk("sat_err_cnt16", err_cnt, 16'd28);
    chk("sat_lock", lock4, 1'b1);
    chk("sat_bit_cnt", bit_cnt4, 32'd48);
    send(1'b1, 1'b1);
    chk("clr_err_cnt4", err_cnt4, 4'h0);
    chk("clr_err_pulse", err4, 1'b1);
    chk("clr_err_cnt16", err_cnt, 16'd0);

    // valid_i low: everything holds
    idle();
    chk("idle_err_pulse", err, 1'b0);
    chk("idle_bit_cnt", bit_cnt, 32'd0);

    // case 4: constant-zero stream
    rst = 1'b1; tick(); rst = 1'b0;
    seen_lock = 1'b0;
    for (int i = 0; i < 200; i++) begin
      data = 1'b0; valid = 1'b1;
      tick();
      if (lock) seen_lock = 1'b1;
    end
    chk("zero_never_lock", seen_lock, 1'b0);
    chk("zero_err_cnt", err_cnt, 16'd0);
    chk("zero_bit_cnt", bit_cnt, 32'd0);

    // case 6: random valid gaps, same lock point in valid samples
    rst = 1'b1; tick(); rst = 1'b0;
    nvalid = 0;
    iter = 0;
    while (nvalid < 46 && iter < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1'b0, 1'b0);
        nvalid++;
      end else begin
        idle();
      end
      iter++;
    end
    chk("gap_budget", (iter < 1000), 1'b1);
    chk("gap_nolock_46", lock, 1'b0);
    chk("gap_state_46", state, 2'b01);
    idle(); idle();
    chk("gap_hold_state", state, 2'b01);
    send_n(1);
    chk("gap_lock_47", lock, 1'b1);
    send_n(3);
    chk("gap_bit_cnt", bit_cnt, 32'd3);

    rst = 1'b1;
    send(1'b0, 1'b0);
    chk("rst_locked_state", state, 2'b00);
    chk("rst_locked_lock", lock, 1'b0);
    chk("rst_locked_bits", bit_cnt, 32'd0);
    chk("rst_locked_errs", err_cnt, 16'd0);
    chk("rst_locked_pulse", err, 1'b0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
